// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the CNN front-end window generator.
//   IMG_W, IMG_H : image geometry in pixels
//   K            : window edge length
//   PIX_W        : bits per pixel
//   WIN_W        : packed window width (K*K*PIX_W)
//   LB_ROWS      : number of buffered image rows (K-1)
//   PTR_W        : width of the circular line-buffer row pointer
//   state_t      : window generator FSM encoding
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int K       = 5;
  localparam int PIX_W   = 8;
  localparam int WIN_W   = K * K * PIX_W;
  localparam int LB_ROWS = K - 1;
  localparam int PTR_W   = (LB_ROWS > 1) ? $clog2(LB_ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    FLUSH   = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  // The line buffer holding an older image row rotates with the row pointer:
  // window row i (counting from the top) lives in slot (ptr + i) mod LB_ROWS.
  function automatic logic [PTR_W-1:0] slotOf(input logic [PTR_W-1:0] ptr, input int offset);
    int s;
    s = (int'(ptr) + offset) % LB_ROWS;
    return PTR_W'(s);
  endfunction

endpackage

// File: rtl/line_buffer_row.sv
// ---------------------------------------------------------------------------
// line_buffer_row
// One image row of storage: DEPTH entries of WIDTH bits, synchronous write,
// combinational read. Contents are never reset.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : shared read/write column address
//   wdata_i : data written at addr_i on the rising edge when we_i is high
//   rdata_o : current contents at addr_i (old value during a write cycle)
// ---------------------------------------------------------------------------
module line_buffer_row #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
// Turns a raster-scanned IMG_H x IMG_W pixel stream into every valid KxK
// window in raster order, each tagged with its top-left corner (X, Y).
//   CLK       : clock
//   RST       : asynchronous active-high reset
//   START     : frame start pulse, honoured only in IDLE
//   PIX_VALID : PIX_IN holds the next raster pixel
//   PIX_IN    : pixel value
//   PIX_READY : a pixel can be accepted this cycle
//   WIN_VALID : IMGIN/X/Y hold a window
//   WIN_READY : consumer takes the window this cycle
//   X, Y      : window top-left column / row
//   IMGIN     : window, byte (i*K+j) = pixel(Y+i, X+j)
//   DONE      : one-cycle pulse after the final window is taken
//   BUSY      : high whenever not IDLE
// ---------------------------------------------------------------------------
module conv_window_gen
  import cnn_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             PIX_VALID,
  input  logic [PIX_W-1:0] PIX_IN,
  output logic             PIX_READY,
  output logic             WIN_VALID,
  input  logic             WIN_READY,
  output logic [4:0]       X,
  output logic [4:0]       Y,
  output logic [WIN_W-1:0] IMGIN,
  output logic             DONE,
  output logic             BUSY
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_WIN0 = ROW_W'(K - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LB_ROWS - 1);

  state_t state_q, state_d;

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [PIX_W-1:0] win_q [K][K];
  logic [PIX_W-1:0] win_d [K][K];

  logic             winValid_q, winValid_d;
  logic [4:0]       x_q, x_d;
  logic [4:0]       y_q, y_d;
  logic [WIN_W-1:0] imgin_q, imgin_d;

  logic [PIX_W-1:0] lbRdata [LB_ROWS];

  logic pixReady;
  logic pixAccept;
  logic winAccept;
  logic lastPix;
  logic winComplete;

  // A pixel may enter only while streaming and when the output register is
  // either empty or being drained this very cycle.
  assign pixReady    = (state_q == STREAM) && (!winValid_q || WIN_READY);
  assign pixAccept   = PIX_VALID && pixReady;
  assign winAccept   = winValid_q && WIN_READY;
  assign lastPix     = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign winComplete = (row_q >= ROW_WIN0) && (col_q >= COL_WIN0);

  // Only the slot the row pointer names is written; it holds row r-K+1,
  // which is read out into the window before being overwritten by row r.
  for (genvar g = 0; g < LB_ROWS; g++) begin : gLineBuf
    line_buffer_row #(
      .DEPTH (IMG_W),
      .WIDTH (PIX_W)
    ) uRow (
      .clk_i   (CLK),
      .we_i    (pixAccept && (ptr_q == PTR_W'(g))),
      .addr_i  (col_q),
      .wdata_i (PIX_IN),
      .rdata_o (lbRdata[g])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = STREAM;
      STREAM:  if (pixAccept && lastPix) state_d = FLUSH;
      FLUSH:   if (winAccept) state_d = DONE_ST;
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position and circular row pointer; everything restarts on START.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    ptr_d = ptr_q;
    if ((state_q == IDLE) && START) begin
      row_d = '0;
      col_d = '0;
      ptr_d = '0;
    end else if (pixAccept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Shift window: every row moves one column left and the new right-hand
  // column is the K-1 buffered rows above plus the incoming pixel.
  always_comb begin
    win_d = win_q;
    if (pixAccept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
      end
      for (int i = 0; i < K - 1; i++) begin
        win_d[i][K-1] = lbRdata[slotOf(ptr_q, i)];
      end
      win_d[K-1][K-1] = PIX_IN;
    end
  end

  // A completing pixel loads the output register even while the previous
  // window is leaving in the same cycle; otherwise a taken window empties it.
  always_comb begin
    winValid_d = winValid_q;
    x_d        = x_q;
    y_d        = y_q;
    imgin_d    = imgin_q;
    if (pixAccept && winComplete) begin
      winValid_d = 1'b1;
      x_d        = 5'(col_q - COL_WIN0);
      y_d        = 5'(row_q - ROW_WIN0);
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          imgin_d[(i*K+j)*PIX_W +: PIX_W] = win_d[i][j];
        end
      end
    end else if (winAccept) begin
      winValid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      ptr_q      <= '0;
      winValid_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      imgin_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ptr_q      <= ptr_d;
      winValid_q <= winValid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      imgin_q    <= imgin_d;
    end
  end

  // The shift window needs no reset: each emitted window is built only from
  // columns shifted in during the current row.
  always_ff @(posedge CLK) begin
    win_q <= win_d;
  end

  assign PIX_READY = pixReady;
  assign WIN_VALID = winValid_q;
  assign X         = x_q;
  assign Y         = y_q;
  assign IMGIN     = imgin_q;
  assign DONE      = (state_q == DONE_ST);
  assign BUSY      = (state_q != IDLE);

endmodule
